// File: rtl/inv_sub_bytes_lp_if.sv
// Valid/ready handshake bundle for the InvSubBytes stage: one 128-bit state in, one out.
// Byte i of a state occupies bits [8i:8i+7], with bit 8i as its MSB.
interface inv_sub_bytes_lp_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] blocoIn;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] blocoOut;

  modport slave (
    input  in_valid,
    input  blocoIn,
    input  out_ready,
    output in_ready,
    output out_valid,
    output blocoOut
  );

  modport master (
    output in_valid,
    output blocoIn,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  blocoOut
  );
endinterface

// File: rtl/inv_sub_bytes_lp.sv
// AES InvSubBytes with LANES shared inverse S-boxes, iterating 16/LANES cycles per block.
// A global enable freezes all state and blocks both handshakes.
module inv_sub_bytes_lp #(
  parameter int unsigned LANES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  inv_sub_bytes_lp_if.slave bus
);

  localparam int unsigned ITER = 16 / LANES;
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_bytes_lp: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 inverse S-box, entry 0 first.
  localparam logic [0:255][7:0] InvSboxTab = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [0:127]    data_q;
  logic [0:127]    out_q;
  logic [0:127]    data_upd;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];
  logic            busy_en;

  assign busy_en = (state_q == StBusy) && enable;

  // Lane inputs are held at zero outside active processing to keep the S-box logic quiet.
  always_comb begin
    data_upd = data_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l]  = busy_en ? data_q[(32'(cnt_q) * LANES + l) * 8 +: 8] : 8'h00;
      lane_out[l] = InvSboxTab[lane_in[l]];
      data_upd[(32'(cnt_q) * LANES + l) * 8 +: 8] = lane_out[l];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            data_q  <= bus.blocoIn;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          data_q <= data_upd;
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            out_q   <= data_upd;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && enable && reset;
  assign bus.out_valid = (state_q == StDone) && enable;
  assign bus.blocoOut  = out_q;

endmodule

// File: tb/tb_inv_sub_bytes_lp.sv
// Bench for inv_sub_bytes_lp: directed vectors on LANES=1/4/16, handshake corner cases,
// and a random stream checked against a forward S-box built from GF(2^8) arithmetic.
module tb_inv_sub_bytes_lp;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         in_valid;
  logic         out_ready;
  logic [0:127] blocoIn;

  int n_pass  = 0;
  int n_total = 0;

  localparam int NBLK = 1000;

  inv_sub_bytes_lp_if bi1 ();
  inv_sub_bytes_lp_if bi4 ();
  inv_sub_bytes_lp_if bi16 ();

  assign bi1.in_valid   = in_valid;
  assign bi1.blocoIn    = blocoIn;
  assign bi1.out_ready  = out_ready;
  assign bi4.in_valid   = in_valid;
  assign bi4.blocoIn    = blocoIn;
  assign bi4.out_ready  = out_ready;
  assign bi16.in_valid  = in_valid;
  assign bi16.blocoIn   = blocoIn;
  assign bi16.out_ready = out_ready;

  inv_sub_bytes_lp #(.LANES(1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .bus   (bi1)
  );

  inv_sub_bytes_lp #(.LANES(4)) u_dut4 (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .bus   (bi4)
  );

  inv_sub_bytes_lp #(.LANES(16)) u_dut16 (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .bus   (bi16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  logic [7:0] fwd [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [127:0] fwd_sub(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd[x[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send4(input logic [127:0] d);
    int n = 0;
    while (!bi4.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bi4.in_ready) begin
      n_total++;
      $display("FAIL send4_timeout: in_ready still 0 after %0d cycles, expected 1", n);
    end
    blocoIn  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  vec_t         vecs [3];
  int           l1, l4, l16, lat, sent, rcvd, n;
  logic [127:0] cur_x;
  logic [7:0]   y;
  bit           fired;
  logic [127:0] expq [$];

  initial begin
    // Forward S-box from multiplicative inverse plus affine map.
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      if (x != 0) begin
        for (int c = 1; c < 256; c++) if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      end
      fwd[x] = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    end

    vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    vecs[1] = '{128'h637c0016ed6363636363636363636363, 128'h000152ff530000000000000000000000};
    vecs[2] = '{128'h60814fdc222a908846eeb814de5e0bdb, 128'h909192939495969798999a9b9c9d9e9f};

    // Reset state
    reset = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; blocoIn = '0;
    repeat (3) tick();
    check("reset_in_ready", 128'(bi4.in_ready), 128'd0);
    check("reset_out_valid", 128'(bi4.out_valid), 128'd0);
    check("reset_blocoOut", bi4.blocoOut, 128'd0);
    reset = 1'b1;
    tick();
    check("idle_in_ready", 128'(bi4.in_ready), 128'd1);

    // Directed table on all three lane counts at once
    for (int v = 0; v < 3; v++) begin
      n = 0;
      while (!(bi1.in_ready && bi4.in_ready && bi16.in_ready) && n < 100) begin
        tick();
        n++;
      end
      blocoIn  = vecs[v].din;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      l1 = 0; l4 = 0; l16 = 0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (bi1.out_valid && l1 == 0) begin
          l1 = k;
          check($sformatf("tbl%0d_out_l1", v), bi1.blocoOut, vecs[v].dout);
        end
        if (bi4.out_valid && l4 == 0) begin
          l4 = k;
          check($sformatf("tbl%0d_out_l4", v), bi4.blocoOut, vecs[v].dout);
        end
        if (bi16.out_valid && l16 == 0) begin
          l16 = k;
          check($sformatf("tbl%0d_out_l16", v), bi16.blocoOut, vecs[v].dout);
        end
        if (k == 5) check($sformatf("tbl%0d_in_ready_back", v), 128'(bi4.in_ready), 128'd1);
      end
      check($sformatf("tbl%0d_lat_l1", v), 128'(l1), 128'd16);
      check($sformatf("tbl%0d_lat_l4", v), 128'(l4), 128'd4);
      check($sformatf("tbl%0d_lat_l16", v), 128'(l16), 128'd1);
    end

    // Backpressure in DONE, with a competing input that must be ignored
    out_ready = 1'b0;
    send4(vecs[0].din);
    repeat (4) tick();
    check("bp_out_valid", 128'(bi4.out_valid), 128'd1);
    in_valid = 1'b1;
    blocoIn  = vecs[2].din;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_hold_valid", 128'(bi4.out_valid), 128'd1);
      check("bp_hold_in_ready", 128'(bi4.in_ready), 128'd0);
      check("bp_hold_data", bi4.blocoOut, vecs[0].dout);
    end
    enable    = 1'b0;
    out_ready = 1'b1;
    tick();
    check("done_freeze_valid", 128'(bi4.out_valid), 128'd0);
    enable = 1'b1;
    #1;
    check("done_resume_valid", 128'(bi4.out_valid), 128'd1);
    in_valid = 1'b0;
    tick();
    check("bp_release_valid", 128'(bi4.out_valid), 128'd0);
    check("bp_release_in_ready", 128'(bi4.in_ready), 128'd1);
    check("bp_release_data", bi4.blocoOut, vecs[0].dout);
    repeat (6) tick();
    check("bp_no_phantom", 128'(bi4.out_valid), 128'd0);

    // Enable drop: idle, then 5 frozen cycles at cnt=2
    enable = 1'b0;
    #1;
    check("idle_freeze_in_ready", 128'(bi4.in_ready), 128'd0);
    enable = 1'b1;
    send4(vecs[0].din);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) enable = 1'b0;
      if (k == 4) begin
        check("en_off_out_valid", 128'(bi4.out_valid), 128'd0);
        check("en_off_in_ready", 128'(bi4.in_ready), 128'd0);
      end
      if (k == 7) enable = 1'b1;
      if (bi4.out_valid && lat == 0) begin
        lat = k;
        check("en_result", bi4.blocoOut, vecs[0].dout);
      end
    end
    check("en_latency", 128'(lat), 128'd9);

    // Asynchronous reset mid-BUSY
    send4(vecs[2].din);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(bi4.out_valid), 128'd0);
    check("rst_mid_blocoOut", bi4.blocoOut, 128'd0);
    check("rst_mid_in_ready", 128'(bi4.in_ready), 128'd0);
    tick();
    reset = 1'b1;
    tick();
    send4(vecs[1].din);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bi4.out_valid && lat == 0) begin
        lat = k;
        check("rst_after_result", bi4.blocoOut, vecs[1].dout);
      end
    end
    check("rst_after_latency", 128'(lat), 128'd4);

    // Random stream: input is SubBytes(x), output must be x, in order
    sent = 0; rcvd = 0; in_valid = 1'b0; out_ready = 1'b1; enable = 1'b1; cur_x = '0;
    for (int cyc = 0; cyc < 60000 && rcvd < NBLK; cyc++) begin
      @(negedge clock);
      fired = 1'b0;
      if (in_valid && bi4.in_ready) begin
        expq.push_back(cur_x);
        sent++;
        fired = 1'b1;
      end
      if (bi4.out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_total++;
          $display("FAIL rand_extra: got %h, expected no output", bi4.blocoOut);
        end else begin
          check("rand_out", bi4.blocoOut, expq.pop_front());
        end
        rcvd++;
      end
      tick();
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid || fired) begin
        if (sent < NBLK && $urandom_range(0, 3) != 0) begin
          cur_x    = {$urandom, $urandom, $urandom, $urandom};
          blocoIn  = fwd_sub(cur_x);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("rand_count", 128'(rcvd), 128'(NBLK));
    check("rand_queue_empty", 128'(expq.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
